// File: rtl/dev_bus_arbiter_pkg.sv
// Shared types and constants for the two-master device-bus arbiter.
package dev_arb_pkg;

  localparam int unsigned DEFAULT_MAX_HOLD = 4;
  localparam int unsigned CNT_W            = 4;
  localparam int unsigned ADDR_W           = 30;
  localparam int unsigned BE_W             = 4;
  localparam int unsigned DATA_W           = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_M0   = 2'b01,
    OWN_M1   = 2'b10
  } ownerT;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wd;
    logic              we;
  } busReqT;

  // Hold counter increments but sticks at all-ones.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/dev_bus_arbiter_rr_pick.sv
// Next-owner selection: round-robin tie-break from idle, hold-limited rotation
// while owned, optional lock that pins a DMA owner.
module arb_rr_pick
  import dev_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       owner,
  input  logic [CNT_W-1:0] cnt,
  input  logic             lastM1,
  input  logic             lockM1,
  output logic [1:0]       nextOwner
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

  logic holdDone;
  assign holdDone = (cnt >= HOLD_LIM);

  always_comb begin
    nextOwner = OWN_NONE;
    case (owner)
      OWN_M0: begin
        if (!req0)                nextOwner = req1 ? OWN_M1 : OWN_NONE;
        else if (req1 && holdDone) nextOwner = OWN_M1;
        else                      nextOwner = OWN_M0;
      end
      OWN_M1: begin
        if (!req1)                           nextOwner = req0 ? OWN_M0 : OWN_NONE;
        else if (req0 && holdDone && !lockM1) nextOwner = OWN_M0;
        else                                 nextOwner = OWN_M1;
      end
      default: begin
        // Tie from idle goes to whoever did not win last time.
        if (req0 && req1) nextOwner = lastM1 ? OWN_M0 : OWN_M1;
        else if (req0)    nextOwner = OWN_M0;
        else if (req1)    nextOwner = OWN_M1;
        else              nextOwner = OWN_NONE;
      end
    endcase
  end

endmodule

// File: rtl/dev_bus_arbiter.sv
// CPU/DMA arbiter onto the device bus: owner/hold/last-winner registers plus
// combinational bus and read-data muxing. Define DEVARB_LOCK_EN to add m1_lock.
module dev_bus_arbiter
  import dev_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic        clk,
  input  logic        reset,
`ifdef DEVARB_LOCK_EN
  input  logic        m1_lock,
`endif
  input  logic        m0_req,
  input  logic [31:2] m0_addr,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_wd,
  input  logic        m0_we,
  input  logic        m1_req,
  input  logic [31:2] m1_addr,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_wd,
  input  logic        m1_we,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic [31:0] m0_rd,
  output logic [31:0] m1_rd,
  output logic [31:2] PrAddr,
  output logic [3:0]  PrBe,
  output logic [31:0] PrWD,
  output logic        PrWE,
  input  logic [31:0] PrRD
);

  ownerT            owner;
  ownerT            nextOwner;
  logic [1:0]       pickOwner;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nextCnt;
  logic             lastM1;
  logic             nextLastM1;
  logic             lockM1;
  busReqT           req0Bus;
  busReqT           req1Bus;
  busReqT           prBus;

`ifdef DEVARB_LOCK_EN
  assign lockM1 = m1_lock;
`else
  assign lockM1 = 1'b0;
`endif

  assign req0Bus = '{addr: m0_addr, be: m0_be, wd: m0_wd, we: m0_we};
  assign req1Bus = '{addr: m1_addr, be: m1_be, wd: m1_wd, we: m1_we};

  arb_rr_pick #(
    .MAX_HOLD (MAX_HOLD)
  ) uPick (
    .req0      (m0_req),
    .req1      (m1_req),
    .owner     (owner),
    .cnt       (cnt),
    .lastM1    (lastM1),
    .lockM1    (lockM1),
    .nextOwner (pickOwner)
  );

  // State register; reset leaves M1 as last winner so M0 takes the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner  <= OWN_NONE;
      cnt    <= '0;
      lastM1 <= 1'b1;
    end else begin
      owner  <= nextOwner;
      cnt    <= nextCnt;
      lastM1 <= nextLastM1;
    end
  end

  // Next-state: counter restarts on any owner change, otherwise counts owned beats.
  always_comb begin
    nextOwner  = ownerT'(pickOwner);
    nextCnt    = cnt;
    nextLastM1 = lastM1;
    if (nextOwner != owner) begin
      nextCnt = '0;
      if (nextOwner == OWN_M0)      nextLastM1 = 1'b0;
      else if (nextOwner == OWN_M1) nextLastM1 = 1'b1;
    end else if (owner != OWN_NONE) begin
      nextCnt = satInc(cnt);
    end
  end

  // Outputs: grant is owner-and-request, bus and read data zero when idle.
  always_comb begin
    m0_gnt = (owner == OWN_M0) && m0_req && !reset;
    m1_gnt = (owner == OWN_M1) && m1_req && !reset;
    prBus  = '0;
    if (m0_gnt)      prBus = req0Bus;
    else if (m1_gnt) prBus = req1Bus;
    PrAddr = prBus.addr;
    PrBe   = prBus.be;
    PrWD   = prBus.wd;
    PrWE   = prBus.we;
    m0_rd  = m0_gnt ? PrRD : '0;
    m1_rd  = m1_gnt ? PrRD : '0;
  end

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Scoreboard bench for dev_bus_arbiter: the driver queues per-cycle expectations,
// a negedge monitor pops and compares. Lock scenario runs when DEVARB_LOCK_EN is set.
module tb_dev_bus_arbiter;

  typedef struct {
    int          cyc;
    logic        g0;
    logic        g1;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } expT;

  logic        clk;
  logic        reset;
  logic        m0_req, m1_req;
  logic [31:2] m0_addr, m1_addr;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_wd, m1_wd;
  logic        m0_we, m1_we;
  logic        m0_gnt, m1_gnt;
  logic [31:0] m0_rd, m1_rd;
  logic [31:2] PrAddr;
  logic [3:0]  PrBe;
  logic [31:0] PrWD;
  logic        PrWE;
  logic [31:0] PrRD;
`ifdef DEVARB_LOCK_EN
  logic        m1_lock;
  logic        cfgLock;
`endif

  // Per-master fields staged here and applied at the start of each driven cycle.
  logic [29:0] cfgA0, cfgA1;
  logic [3:0]  cfgBe0, cfgBe1;
  logic [31:0] cfgWd0, cfgWd1, cfgRd;
  logic        cfgWe0, cfgWe1;

  expT q[$];
  int  checks = 0;
  int  errors = 0;
  int  cycNo  = 0;

  dev_bus_arbiter #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .reset   (reset),
`ifdef DEVARB_LOCK_EN
    .m1_lock (m1_lock),
`endif
    .m0_req  (m0_req),
    .m0_addr (m0_addr),
    .m0_be   (m0_be),
    .m0_wd   (m0_wd),
    .m0_we   (m0_we),
    .m1_req  (m1_req),
    .m1_addr (m1_addr),
    .m1_be   (m1_be),
    .m1_wd   (m1_wd),
    .m1_we   (m1_we),
    .m0_gnt  (m0_gnt),
    .m1_gnt  (m1_gnt),
    .m0_rd   (m0_rd),
    .m1_rd   (m1_rd),
    .PrAddr  (PrAddr),
    .PrBe    (PrBe),
    .PrWD    (PrWD),
    .PrWE    (PrWE),
    .PrRD    (PrRD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int cyc, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  // One driven cycle: apply inputs just after the edge and queue what the bus must show.
  task automatic cyc(input logic rst, input logic r0, input logic r1,
                     input logic eg0, input logic eg1);
    expT e;
    @(posedge clk);
    #1;
    cycNo++;
    reset   = rst;
    m0_req  = r0;      m1_req  = r1;
    m0_addr = cfgA0;   m1_addr = cfgA1;
    m0_be   = cfgBe0;  m1_be   = cfgBe1;
    m0_wd   = cfgWd0;  m1_wd   = cfgWd1;
    m0_we   = cfgWe0;  m1_we   = cfgWe1;
    PrRD    = cfgRd;
`ifdef DEVARB_LOCK_EN
    m1_lock = cfgLock;
`endif
    e.cyc = cycNo; e.g0 = eg0; e.g1 = eg1;
    e.addr = '0; e.be = '0; e.wd = '0; e.we = 1'b0; e.rd0 = '0; e.rd1 = '0;
    if (eg0) begin
      e.addr = cfgA0; e.be = cfgBe0; e.wd = cfgWd0; e.we = cfgWe0; e.rd0 = cfgRd;
    end else if (eg1) begin
      e.addr = cfgA1; e.be = cfgBe1; e.wd = cfgWd1; e.we = cfgWe1; e.rd1 = cfgRd;
    end
    q.push_back(e);
  endtask

  task automatic run(input int n, input logic rst, input logic r0, input logic r1,
                     input logic eg0, input logic eg1);
    for (int i = 0; i < n; i++) cyc(rst, r0, r1, eg0, eg1);
  endtask

  // Monitor: samples mid-cycle, away from the rising edge.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("m0_gnt", e.cyc, 32'(m0_gnt), 32'(e.g0));
        chk("m1_gnt", e.cyc, 32'(m1_gnt), 32'(e.g1));
        chk("PrAddr", e.cyc, 32'(PrAddr), 32'(e.addr));
        chk("PrBe",   e.cyc, 32'(PrBe),   32'(e.be));
        chk("PrWD",   e.cyc, PrWD,        e.wd);
        chk("PrWE",   e.cyc, 32'(PrWE),   32'(e.we));
        chk("m0_rd",  e.cyc, m0_rd,       e.rd0);
        chk("m1_rd",  e.cyc, m1_rd,       e.rd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cycNo);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
    m0_addr = '0; m1_addr = '0; m0_be = '0; m1_be = '0;
    m0_wd = '0; m1_wd = '0; m0_we = 1'b0; m1_we = 1'b0; PrRD = '0;
    cfgA0 = 30'h1fc0;     cfgBe0 = 4'hf; cfgWd0 = 32'h0000_1234; cfgWe0 = 1'b1;
    cfgA1 = 30'h0000_400; cfgBe1 = 4'h3; cfgWd1 = 32'hdead_beef; cfgWe1 = 1'b0;
    cfgRd = 32'haabb_ccdd;
`ifdef DEVARB_LOCK_EN
    m1_lock = 1'b0; cfgLock = 1'b0;
`endif

    // Reset state, with requests asserted during reset too
    run(2, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);

    // Single CPU write: one-cycle grant latency, then release back to idle
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    run(2, 0, 0, 0, 0, 0);

    // Tie after reset: CPU first, DMA right after CPU releases
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 1);
    run(2, 0, 0, 0, 0, 0);

    // Both held: 4/4 alternation, DMA read data routed only to m1_rd
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    for (int k = 0; k < 2; k++) begin
      run(4, 0, 1, 1, 1, 0);
      run(4, 0, 1, 1, 0, 1);
    end
    run(2, 0, 0, 0, 0, 0);

    // Reset during CPU write ownership, re-grant after reset drops
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);

    // Long solo run saturates the hold counter; a late DMA request rotates at once
    run(18, 0, 1, 0, 1, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 0, 1);
    cyc(0, 0, 1, 0, 1);
    run(2, 0, 0, 0, 0, 0);

`ifdef DEVARB_LOCK_EN
    // Locked DMA keeps the bus past the hold limit until the lock drops
    cyc(1, 0, 0, 0, 0);
    cfgLock = 1'b1;
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 1);
    run(15, 0, 1, 1, 0, 1);
    cfgLock = 1'b0;
    cyc(0, 1, 1, 0, 1);
    cyc(0, 1, 1, 1, 0);
    run(2, 0, 0, 0, 0, 0);
`endif

    // Let the monitor drain, then confirm nothing was left unchecked
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    chk("queue_drained", cycNo, 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
